// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared types and widths for the equalizer scheduler and core
package eq_pkg;

    localparam int DATA_W  = 32;
    localparam int LEVEL_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        RUN_L,
        RUN_R,
        WAIT_OUT,
        LOAD
    } eq_state_t;

    // Core coefficient ports take the raw switch pattern with a zero pad bit.
    function automatic logic [LEVEL_W:0] extend_level(input logic [LEVEL_W-1:0] level);
        return {1'b0, level};
    endfunction

endpackage

// File: rtl/eq_button_debounce.sv
// rtl/eq_button_debounce.sv - synchronizer, stability counter and rising-edge pulse for a pushbutton
module eq_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             cnt_full;

    assign cnt_full = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    // Pulse in the same cycle the new level is accepted, so press-to-load stays minimal.
    assign pulse    = sync2 && !stable && cnt_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt_full) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eq_frame_scheduler.sv
// rtl/eq_frame_scheduler.sv - time-shares one equalizer core across left/right samples of each frame
module eq_frame_scheduler
    import eq_pkg::*;
#(
    parameter int DATA_W          = eq_pkg::DATA_W,
    parameter int LEVEL_W         = eq_pkg::LEVEL_W,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               audio_in_available,
    input  logic [DATA_W-1:0]  left_channel_audio_in,
    input  logic [DATA_W-1:0]  right_channel_audio_in,
    output logic               read_audio_in,
    input  logic               audio_out_allowed,
    output logic               write_audio_out,
    output logic [DATA_W-1:0]  left_channel_audio_out,
    output logic [DATA_W-1:0]  right_channel_audio_out,
    input  logic               set,
    input  logic [LEVEL_W-1:0] bass_level,
    input  logic [LEVEL_W-1:0] mid_level,
    input  logic [LEVEL_W-1:0] treble_level,
    output logic               eq_start,
    output logic [DATA_W-1:0]  eq_d_in,
    input  logic [DATA_W-1:0]  eq_d_out,
    input  logic               eq_done,
    output logic               eq_load,
    output logic [LEVEL_W:0]   eq_bass,
    output logic [LEVEL_W:0]   eq_mid,
    output logic [LEVEL_W:0]   eq_treble,
    output logic               busy,
    output logic [7:0]         overrun_count,
    output logic               timeout_flag
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    eq_state_t         state;
    eq_state_t         state_nx;
    logic [DATA_W-1:0] left_smp;
    logic [DATA_W-1:0] right_smp;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              right_start;
    logic              load_pending;
    logic              avail_q;
    logic              set_pulse;
    logic              read_s;
    logic              write_s;
    logic              start_s;
    logic              load_s;
    logic              chan_end;

    eq_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .button(set),
        .pulse (set_pulse)
    );

    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    // The cycle that starts the right channel must not see the left channel's stale completion.
    assign chan_end = (eq_done || tmo_hit) && !right_start;

    always_comb begin
        state_nx = state;
        read_s   = 1'b0;
        write_s  = 1'b0;
        start_s  = 1'b0;
        load_s   = 1'b0;
        case (state)
            IDLE: begin
                if (load_pending) begin
                    state_nx = LOAD;
                end else if (audio_in_available) begin
                    read_s   = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                start_s  = 1'b1;
                state_nx = RUN_L;
            end
            RUN_L: begin
                if (eq_done || tmo_hit) state_nx = RUN_R;
            end
            RUN_R: begin
                start_s = right_start;
                if (chan_end) state_nx = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (audio_out_allowed) begin
                    write_s  = 1'b1;
                    state_nx = IDLE;
                end
            end
            LOAD: begin
                load_s   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The pop is combinational from an input, so hold it low while reset is asserted.
    assign read_audio_in   = read_s && reset;
    assign write_audio_out = write_s;
    assign eq_start        = start_s;
    assign eq_load         = load_s;
    assign busy            = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state                   <= IDLE;
            left_smp                <= '0;
            right_smp               <= '0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            eq_d_in                 <= '0;
            eq_bass                 <= '0;
            eq_mid                  <= '0;
            eq_treble               <= '0;
            tmo_cnt                 <= '0;
            right_start             <= 1'b0;
            load_pending            <= 1'b0;
            avail_q                 <= 1'b0;
            overrun_count           <= '0;
            timeout_flag            <= 1'b0;
        end else begin
            state       <= state_nx;
            avail_q     <= audio_in_available;
            right_start <= 1'b0;

            if (state != IDLE && audio_in_available && !avail_q && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;

            if (set_pulse)
                load_pending <= 1'b1;
            else if (state == LOAD)
                load_pending <= 1'b0;

            if (start_s)
                tmo_cnt <= '0;
            else if (state == RUN_L || state == RUN_R)
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (state_nx == CAPTURE) begin
                        left_smp  <= left_channel_audio_in;
                        right_smp <= right_channel_audio_in;
                        eq_d_in   <= left_channel_audio_in;
                    end else if (state_nx == LOAD) begin
                        eq_bass   <= extend_level(bass_level);
                        eq_mid    <= extend_level(mid_level);
                        eq_treble <= extend_level(treble_level);
                    end
                end
                RUN_L: begin
                    if (eq_done || tmo_hit) begin
                        left_channel_audio_out <= eq_done ? eq_d_out : left_smp;
                        if (!eq_done) timeout_flag <= 1'b1;
                        eq_d_in     <= right_smp;
                        right_start <= 1'b1;
                    end
                end
                RUN_R: begin
                    if (chan_end) begin
                        right_channel_audio_out <= eq_done ? eq_d_out : right_smp;
                        if (!eq_done) timeout_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_frame_scheduler.sv
// tb/tb_eq_frame_scheduler.sv - scoreboard bench for eq_frame_scheduler with a 4-cycle core model
module tb_eq_frame_scheduler;
    localparam int DW = 32;
    localparam int LW = 5;

    logic          clk;
    logic          reset;
    logic          avail;
    logic [DW-1:0] left_in;
    logic [DW-1:0] right_in;
    logic          read_audio_in;
    logic          allowed;
    logic          write_audio_out;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          set;
    logic [LW-1:0] bass_level;
    logic [LW-1:0] mid_level;
    logic [LW-1:0] treble_level;
    logic          eq_start;
    logic [DW-1:0] eq_d_in;
    logic [DW-1:0] eq_d_out;
    logic          eq_done;
    logic          eq_load;
    logic [LW:0]   eq_bass;
    logic [LW:0]   eq_mid;
    logic [LW:0]   eq_treble;
    logic          busy;
    logic [7:0]    overrun_count;
    logic          timeout_flag;

    eq_frame_scheduler #(
        .DATA_W(DW),
        .LEVEL_W(LW),
        .DEBOUNCE_CYCLES(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .audio_in_available     (avail),
        .left_channel_audio_in  (left_in),
        .right_channel_audio_in (right_in),
        .read_audio_in          (read_audio_in),
        .audio_out_allowed      (allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .set                    (set),
        .bass_level             (bass_level),
        .mid_level              (mid_level),
        .treble_level           (treble_level),
        .eq_start               (eq_start),
        .eq_d_in                (eq_d_in),
        .eq_d_out               (eq_d_out),
        .eq_done                (eq_done),
        .eq_load                (eq_load),
        .eq_bass                (eq_bass),
        .eq_mid                 (eq_mid),
        .eq_treble              (eq_treble),
        .busy                   (busy),
        .overrun_count          (overrun_count),
        .timeout_flag           (timeout_flag)
    );

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            lat;
    } frame_t;

    typedef struct {
        logic [17:0] lv;
        int          writes;
    } load_t;

    frame_t exp_q[$];
    load_t  load_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     last_rd = 0;
    int     rd_cnt = 0;
    int     wr_cnt = 0;
    int     ld_cnt = 0;
    int     strobe_viol = 0;
    logic   core_on;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Core model: result is operand+1, eq_done four cycles after eq_start.
    initial begin
        logic [DW-1:0] op;
        eq_done  = 1'b0;
        eq_d_out = '0;
        forever begin
            @(negedge clk);
            eq_done = 1'b0;
            if (eq_start && core_on) begin
                op = eq_d_in;
                repeat (4) @(negedge clk);
                eq_done  = 1'b1;
                eq_d_out = op + 1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT writes or loads.
    initial begin
        frame_t f;
        load_t  ld;
        forever begin
            @(negedge clk);
            cyc++;
            if ((int'(read_audio_in) + int'(write_audio_out) + int'(eq_start) + int'(eq_load)) > 1)
                strobe_viol++;
            if (read_audio_in) begin
                rd_cnt++;
                last_rd = cyc;
            end
            if (write_audio_out) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got L=%0h R=%0h required no write", left_out, right_out);
                end else begin
                    f = exp_q.pop_front();
                    chk("left_out", left_out, f.l);
                    chk("right_out", right_out, f.r);
                    if (f.lat != 0) chk("latency", cyc - last_rd, f.lat);
                end
            end
            if (eq_load) begin
                ld_cnt++;
                if (load_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got eq_load=1 required 0");
                end else begin
                    ld = load_q.pop_front();
                    chk("load_levels", {eq_bass, eq_mid, eq_treble}, ld.lv);
                    chk("load_after_write", wr_cnt, ld.writes);
                end
            end
        end
    end

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lat);
        frame_t f;
        f.l = l;
        f.r = r;
        f.lat = lat;
        exp_q.push_back(f);
    endtask

    task automatic wait_read();
        int n = 0;
        while (!read_audio_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!read_audio_in) begin
            checks++;
            errors++;
            $display("FAIL read_wait: got no read_audio_in required a pop");
        end
    endtask

    // Leaves the bench 1ns into the CAPTURE cycle.
    task automatic start_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(posedge clk); #1;
        left_in  = l;
        right_in = r;
        avail    = 1'b1;
        @(negedge clk);
        wait_read();
        @(posedge clk); #1;
        avail = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: got busy=%0d pending=%0d required idle", busy, exp_q.size());
        end
    endtask

    initial begin
        int bad;
        int ld_before;
        int rd_before;
        load_t ld;
        reset = 1'b0; avail = 1'b0; allowed = 1'b1; set = 1'b0; core_on = 1'b1;
        left_in = '0; right_in = '0;
        bass_level = '0; mid_level = '0; treble_level = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {read_audio_in, write_audio_out, eq_start, eq_load}, 0);
        chk("rst_outs", {left_out, right_out, eq_d_in}, 0);
        chk("rst_levels", {eq_bass, eq_mid, eq_treble}, 0);
        chk("rst_status", {overrun_count, timeout_flag}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;

        // basic frame, latency 2*4+3
        push_frame(32'h00010001, 32'hFFFF0001, 11);
        start_frame(32'h00010000, 32'hFFFF0000);
        wait_idle();
        chk("single_read", rd_cnt, 1);

        // output backpressure for 20 cycles
        allowed = 1'b0;
        push_frame(32'h12345679, 32'h00010000, 0);
        start_frame(32'h12345678, 32'h0000FFFF);
        repeat (10) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (write_audio_out || !busy) bad++;
        end
        chk("held_cycles_bad", bad, 0);
        @(posedge clk); #1;
        allowed = 1'b1;
        @(negedge clk);
        chk("first_allowed_write", write_audio_out, 1);
        wait_idle();

        // debounced set during a frame, applied after the write
        allowed = 1'b0;
        ld_before = ld_cnt;
        push_frame(32'h00000101, 32'h00000201, 0);
        start_frame(32'h00000100, 32'h00000200);
        @(posedge clk); #1;
        bass_level = 5'b11101; mid_level = 5'd5; treble_level = 5'd0;
        ld.lv = {6'b011101, 6'b000101, 6'b000000};
        ld.writes = wr_cnt + 1;
        load_q.push_back(ld);
        for (int i = 0; i < 6; i++) begin
            set = (i % 2 == 0);
            repeat (2) @(posedge clk); #1;
        end
        set = 1'b1;
        repeat (40) @(posedge clk); #1;
        chk("no_load_in_frame", ld_cnt, ld_before);
        allowed = 1'b1;
        wait_idle();
        repeat (5) @(posedge clk); #1;
        chk("one_load", ld_cnt, ld_before + 1);
        set = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("no_load_on_release", ld_cnt, ld_before + 1);

        // second sample arrives during RUN_R: counted, not popped until IDLE
        rd_before = rd_cnt;
        push_frame(32'h00000001, 32'h00000000, 11);
        push_frame(32'h80000000, 32'h00000011, 11);
        start_frame(32'h00000000, 32'hFFFFFFFF);
        repeat (6) @(posedge clk); #1;
        left_in = 32'h7FFFFFFF; right_in = 32'h00000010; avail = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_extra_read", rd_cnt, rd_before + 1);
        chk("overrun_one", overrun_count, 1);
        wait_read();
        @(posedge clk); #1;
        avail = 1'b0;
        wait_idle();
        chk("overrun_after_pop", overrun_count, 1);

        // overrun saturation
        allowed = 1'b0;
        push_frame(32'h00010000, 32'h80000001, 0);
        start_frame(32'h0000FFFF, 32'h80000000);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1; avail = 1'b1;
            @(posedge clk); #1; avail = 1'b0;
        end
        allowed = 1'b1;
        wait_idle();
        chk("overrun_sat", overrun_count, 255);

        // core never answers: bypass
        chk("timeout_clear", timeout_flag, 0);
        core_on = 1'b0;
        push_frame(32'hCAFEBABE, 32'h13579BDF, 0);
        start_frame(32'hCAFEBABE, 32'h13579BDF);
        wait_idle();
        chk("timeout_flag", timeout_flag, 1);
        chk("timeout_idle", busy, 0);
        core_on = 1'b1;

        // reset during RUN_R discards the frame
        start_frame(32'h11111111, 32'h22222222);
        repeat (6) @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_strobes", {write_audio_out, eq_start, read_audio_in, busy}, 0);
        chk("midrst_outs", {left_out, right_out, eq_d_in}, 0);
        chk("midrst_status", {overrun_count, timeout_flag}, 0);
        repeat (8) @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk); #1;
        push_frame(32'h00000101, 32'hABCDEF01, 11);
        start_frame(32'h00000100, 32'hABCDEF00);
        wait_idle();

        repeat (5) @(posedge clk); #1;
        chk("reads_eq_writes", rd_cnt, wr_cnt + 1);
        chk("strobe_exclusive", strobe_viol, 0);
        chk("scoreboard_empty", exp_q.size() + load_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
